// File: rtl/tcm_dual_port.sv
// -----------------------------------------------------------------------------
// tcm_dual_port
// Dual-port tightly-coupled memory: one instruction read port and one data
// read/write port with byte lanes, both sharing a single word array.
//
// Ports
//   clk      clock
//   rstn     reset, asynchronous, active-high (asserted = 1)
//   ins_a    instruction byte address          ins_e    instruction read request
//   ins      instruction read data             ins_vld  ins valid strobe
//   dat_a    data byte address                 dat_we   per-lane write enable
//   dat_wd   write data                        dat_re   per-lane read enable
//   dat_rd   data read data                    dat_vld  dat_rd valid strobe
//   dat_err  out-of-range strobe for a data access
//
// Addresses are byte addresses; the low LB bits are ignored (word aligned).
// Read latency is RD_LAT cycles (1 or 2). The address is registered and the
// array is read combinationally from the registered index, so a write at the
// same edge as a read request is already visible: write-first for free.
// -----------------------------------------------------------------------------
module tcm_dual_port #(
  parameter int DW     = 32,
  parameter int AW     = 14,
  parameter int ADR_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADR_W-1:0]  ins_a,
  input  logic              ins_e,
  output logic [DW-1:0]     ins,
  output logic              ins_vld,
  input  logic [ADR_W-1:0]  dat_a,
  input  logic [DW/8-1:0]   dat_we,
  input  logic [DW-1:0]     dat_wd,
  input  logic [DW/8-1:0]   dat_re,
  output logic [DW-1:0]     dat_rd,
  output logic              dat_vld,
  output logic              dat_err
);

  localparam int NB    = DW / 8;
  localparam int LB    = (NB > 1) ? $clog2(NB) : 0;
  localparam int DEPTH = 2 ** AW;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0] ins_idx;
  logic [AW-1:0] dat_idx;
  logic          ins_oor;
  logic          dat_oor;

  assign ins_idx = ins_a[AW+LB-1:LB];
  assign dat_idx = dat_a[AW+LB-1:LB];

  // Bits above the word index must all be zero; when the address is exactly
  // wide enough there are no such bits and nothing can be out of range.
  generate
    if (ADR_W > AW + LB) begin : g_oor
      assign ins_oor = |ins_a[ADR_W-1:AW+LB];
      assign dat_oor = |dat_a[ADR_W-1:AW+LB];
    end else begin : g_no_oor
      assign ins_oor = 1'b0;
      assign dat_oor = 1'b0;
    end
  endgenerate

  // Byte-offset bits are deliberately ignored.
  generate
    if (LB > 0) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^{ins_a[LB-1:0], dat_a[LB-1:0]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Word array (not reset; contents survive rstn)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!dat_oor) begin
      for (int i = 0; i < NB; i++) begin
        if (dat_we[i]) begin
          mem[dat_idx][8*i +: 8] <= dat_wd[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: request capture
  // ---------------------------------------------------------------------------
  logic [AW-1:0] ins_idx_q;
  logic          ins_e_q;
  logic          ins_oor_q;
  logic [AW-1:0] dat_idx_q;
  logic [NB-1:0] dat_re_q;
  logic          dat_oor_q;
  logic          dat_wr_q;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ins_idx_q <= '0;
      ins_e_q   <= 1'b0;
      ins_oor_q <= 1'b0;
      dat_idx_q <= '0;
      dat_re_q  <= '0;
      dat_oor_q <= 1'b0;
      dat_wr_q  <= 1'b0;
    end else begin
      ins_idx_q <= ins_idx;
      ins_e_q   <= ins_e;
      ins_oor_q <= ins_oor;
      dat_idx_q <= dat_idx;
      dat_re_q  <= dat_re;
      dat_oor_q <= dat_oor;
      dat_wr_q  <= |dat_we;
    end
  end

  // Combinational array read from the registered index; out-of-range reads
  // return zero. The error flag covers write-only accesses as well.
  logic [DW-1:0] s1_ins_word;
  logic [DW-1:0] s1_dat_word;
  logic          s1_dat_err;

  assign s1_ins_word = ins_oor_q ? '0 : mem[ins_idx_q];
  assign s1_dat_word = dat_oor_q ? '0 : mem[dat_idx_q];
  assign s1_dat_err  = dat_oor_q & (dat_wr_q | (|dat_re_q));

  // ---------------------------------------------------------------------------
  // Optional stage 2, then the output register
  // ---------------------------------------------------------------------------
  logic          fin_ins_e;
  logic [DW-1:0] fin_ins_word;
  logic [NB-1:0] fin_dat_re;
  logic [DW-1:0] fin_dat_word;
  logic          fin_dat_err;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          s2_ins_e;
      logic [DW-1:0] s2_ins_word;
      logic [NB-1:0] s2_dat_re;
      logic [DW-1:0] s2_dat_word;
      logic          s2_dat_err;

      // Data words only load when they will be consumed, which also keeps
      // never-written (X) array contents out of the pipeline when idle.
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
          s2_ins_e    <= 1'b0;
          s2_ins_word <= '0;
          s2_dat_re   <= '0;
          s2_dat_word <= '0;
          s2_dat_err  <= 1'b0;
        end else begin
          s2_ins_e   <= ins_e_q;
          s2_dat_re  <= dat_re_q;
          s2_dat_err <= s1_dat_err;
          if (ins_e_q) begin
            s2_ins_word <= s1_ins_word;
          end
          if (|dat_re_q) begin
            s2_dat_word <= s1_dat_word;
          end
        end
      end

      assign fin_ins_e    = s2_ins_e;
      assign fin_ins_word = s2_ins_word;
      assign fin_dat_re   = s2_dat_re;
      assign fin_dat_word = s2_dat_word;
      assign fin_dat_err  = s2_dat_err;
    end else begin : g_lat1
      assign fin_ins_e    = ins_e_q;
      assign fin_ins_word = s1_ins_word;
      assign fin_dat_re   = dat_re_q;
      assign fin_dat_word = s1_dat_word;
      assign fin_dat_err  = s1_dat_err;
    end
  endgenerate

  // Output register: ins holds when no request, dat_rd lanes hold unless
  // their read enable was set.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ins     <= '0;
      ins_vld <= 1'b0;
      dat_rd  <= '0;
      dat_vld <= 1'b0;
      dat_err <= 1'b0;
    end else begin
      ins_vld <= fin_ins_e;
      dat_vld <= |fin_dat_re;
      dat_err <= fin_dat_err;
      if (fin_ins_e) begin
        ins <= fin_ins_word;
      end
      for (int i = 0; i < NB; i++) begin
        if (fin_dat_re[i]) begin
          dat_rd[8*i +: 8] <= fin_dat_word[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_tcm_dual_port.sv
// -----------------------------------------------------------------------------
// tb_tcm_dual_port
// Drives one RD_LAT=1 and one RD_LAT=2 instance (AW=8, ADR_W=16) with the
// same stimulus and compares both against a word-array reference model whose
// results are delayed by each instance's latency.
// -----------------------------------------------------------------------------
module tb_tcm_dual_port;

  logic        clk;
  logic        rstn;
  logic [15:0] ins_a;
  logic        ins_e;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;

  logic [31:0] ins_1, dat_rd_1, ins_2, dat_rd_2;
  logic        ins_vld_1, dat_vld_1, dat_err_1;
  logic        ins_vld_2, dat_vld_2, dat_err_2;

  tcm_dual_port #(.DW(32), .AW(8), .ADR_W(16), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rstn(rstn),
    .ins_a(ins_a), .ins_e(ins_e), .ins(ins_1), .ins_vld(ins_vld_1),
    .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re),
    .dat_rd(dat_rd_1), .dat_vld(dat_vld_1), .dat_err(dat_err_1)
  );

  tcm_dual_port #(.DW(32), .AW(8), .ADR_W(16), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rstn(rstn),
    .ins_a(ins_a), .ins_e(ins_e), .ins(ins_2), .ins_vld(ins_vld_2),
    .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re),
    .dat_rd(dat_rd_2), .dat_vld(dat_vld_2), .dat_err(dat_err_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: 256 words, addresses >= 0x400 are out of range.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        ie;
    logic [31:0] iv;
    logic [3:0]  re;
    logic [31:0] dv;
    logic        err;
  } res_t;

  logic [31:0] mmem [256];
  res_t        hist [$];
  logic [31:0] exp_ins  [2];
  logic        exp_ivld [2];
  logic [31:0] exp_drd  [2];
  logic        exp_dvld [2];
  logic        exp_err  [2];

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 2; k++) begin
      exp_ins[k]  = '0;
      exp_ivld[k] = 1'b0;
      exp_drd[k]  = '0;
      exp_dvld[k] = 1'b0;
      exp_err[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    res_t r;
    int   dword, iword;
    bit   d_oor, i_oor;
    if (rstn) begin
      model_reset();
      return;
    end
    d_oor = (dat_a >= 16'h0400);
    i_oor = (ins_a >= 16'h0400);
    dword = int'(dat_a) / 4 % 256;
    iword = int'(ins_a) / 4 % 256;
    // writes land first, so reads in the same edge see the new bytes
    if (!d_oor) begin
      for (int l = 0; l < 4; l++) begin
        if (dat_we[l]) mmem[dword][8*l +: 8] = dat_wd[8*l +: 8];
      end
    end
    r.ie  = ins_e;
    r.iv  = i_oor ? 32'h0 : mmem[iword];
    r.re  = dat_re;
    r.dv  = d_oor ? 32'h0 : mmem[dword];
    r.err = d_oor && ((dat_re != 4'h0) || (dat_we != 4'h0));
    hist.push_front(r);
    while (hist.size() > 3) void'(hist.pop_back());
    for (int k = 0; k < 2; k++) begin
      if (hist.size() > k + 1) begin
        res_t e;
        e = hist[k + 1];
        if (e.ie) exp_ins[k] = e.iv;
        exp_ivld[k] = e.ie;
        for (int l = 0; l < 4; l++) begin
          if (e.re[l]) exp_drd[k][8*l +: 8] = e.dv[8*l +: 8];
        end
        exp_dvld[k] = (e.re != 4'h0);
        exp_err[k]  = e.err;
      end else begin
        exp_ivld[k] = 1'b0;
        exp_dvld[k] = 1'b0;
        exp_err[k]  = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("lat1.ins",     ins_1,            exp_ins[0]);
    check("lat1.ins_vld", {31'b0, ins_vld_1}, {31'b0, exp_ivld[0]});
    check("lat1.dat_rd",  dat_rd_1,         exp_drd[0]);
    check("lat1.dat_vld", {31'b0, dat_vld_1}, {31'b0, exp_dvld[0]});
    check("lat1.dat_err", {31'b0, dat_err_1}, {31'b0, exp_err[0]});
    check("lat2.ins",     ins_2,            exp_ins[1]);
    check("lat2.ins_vld", {31'b0, ins_vld_2}, {31'b0, exp_ivld[1]});
    check("lat2.dat_rd",  dat_rd_2,         exp_drd[1]);
    check("lat2.dat_vld", {31'b0, dat_vld_2}, {31'b0, exp_dvld[1]});
    check("lat2.dat_err", {31'b0, dat_err_2}, {31'b0, exp_err[1]});
  endtask

  // Drive inputs, take one rising edge, update the model, check at edge+1.
  task automatic op(input logic [15:0] ia, input logic ie, input logic [15:0] da,
                    input logic [3:0] we, input logic [31:0] wd, input logic [3:0] re);
    ins_a  = ia;
    ins_e  = ie;
    dat_a  = da;
    dat_we = we;
    dat_wd = wd;
    dat_re = re;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    op(16'h0, 1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rstn   = 1'b1;
    ins_a  = '0;
    ins_e  = 1'b0;
    dat_a  = '0;
    dat_we = '0;
    dat_wd = '0;
    dat_re = '0;
    model_reset();
    idle();
    idle();
    rstn = 1'b0;
    idle();

    // fill every word so no read returns undefined contents
    for (int w = 0; w < 256; w++) op(16'h0, 1'b0, 16'(w * 4), 4'hF, $urandom, 4'h0);

    // full-word write then read
    op(16'h0, 1'b0, 16'h0010, 4'hF, 32'hDEADBEEF, 4'h0);
    op(16'h0, 1'b0, 16'h0010, 4'h0, 32'h0, 4'hF);
    idle();
    check("t1.lat1.dat_rd",  dat_rd_1, 32'hDEADBEEF);
    check("t1.lat1.dat_vld", {31'b0, dat_vld_1}, 32'h1);
    check("t1.lat1.dat_err", {31'b0, dat_err_1}, 32'h0);
    idle();
    check("t1.lat2.dat_rd",  dat_rd_2, 32'hDEADBEEF);
    check("t1.lat2.dat_vld", {31'b0, dat_vld_2}, 32'h1);

    // byte lanes
    op(16'h0, 1'b0, 16'h0010, 4'hF, 32'h11223344, 4'h0);
    op(16'h0, 1'b0, 16'h0010, 4'h5, 32'hAABBCCDD, 4'h0);
    op(16'h0, 1'b0, 16'h0024, 4'hF, 32'hFFFFFFFF, 4'h0);
    op(16'h0, 1'b0, 16'h0010, 4'h0, 32'h0, 4'hF);
    op(16'h0, 1'b0, 16'h0024, 4'h0, 32'h0, 4'hF);
    check("t2.lat1.merged", dat_rd_1, 32'h11BB33DD);
    op(16'h0, 1'b0, 16'h0010, 4'h0, 32'h0, 4'h3);
    check("t2.lat1.ones", dat_rd_1, 32'hFFFFFFFF);
    idle();
    check("t2.lat1.lanes", dat_rd_1, 32'hFFFF33DD);
    idle();
    check("t2.lat2.lanes", dat_rd_2, 32'hFFFF33DD);

    // write-first across ports
    op(16'h0020, 1'b1, 16'h0020, 4'hF, 32'h12345678, 4'h0);
    idle();
    check("t3.lat1.ins", ins_1, 32'h12345678);
    check("t3.lat1.ins_vld", {31'b0, ins_vld_1}, 32'h1);
    idle();
    check("t3.lat2.ins", ins_2, 32'h12345678);
    check("t3.lat2.ins_vld", {31'b0, ins_vld_2}, 32'h1);

    // out of range
    op(16'h0, 1'b0, 16'h0000, 4'hF, 32'h55AA55AA, 4'h0);
    op(16'h0, 1'b0, 16'h0400, 4'hF, 32'hCAFEF00D, 4'h0);
    idle();
    check("t4.lat1.wr_err", {31'b0, dat_err_1}, 32'h1);
    check("t4.lat1.wr_vld", {31'b0, dat_vld_1}, 32'h0);
    op(16'h0, 1'b0, 16'h0400, 4'h0, 32'h0, 4'hF);
    op(16'h0, 1'b0, 16'h0000, 4'h0, 32'h0, 4'hF);
    check("t4.lat1.rd_zero", dat_rd_1, 32'h0);
    check("t4.lat1.rd_err", {31'b0, dat_err_1}, 32'h1);
    idle();
    check("t4.lat1.word0", dat_rd_1, 32'h55AA55AA);
    check("t4.lat1.no_err", {31'b0, dat_err_1}, 32'h0);
    op(16'h0400, 1'b1, 16'h0, 4'h0, 32'h0, 4'h0);
    idle();
    check("t4.lat1.ins_oor", ins_1, 32'h0);
    check("t4.lat1.ins_oor_vld", {31'b0, ins_vld_1}, 32'h1);
    check("t4.lat1.ins_no_err", {31'b0, dat_err_1}, 32'h0);

    // back-to-back instruction reads on the two-cycle instance
    for (int w = 0; w < 4; w++) op(16'h0, 1'b0, 16'(w * 4), 4'hF, 32'(w + 1), 4'h0);
    for (int j = 0; j < 7; j++) begin
      op(16'(j * 4), (j < 4), 16'h0, 4'h0, 32'h0, 4'h0);
      if (j >= 2 && j <= 5) begin
        check("t5.lat2.ins", ins_2, 32'(j - 1));
        check("t5.lat2.ins_vld", {31'b0, ins_vld_2}, 32'h1);
      end else if (j == 6) begin
        check("t5.lat2.ins_hold", ins_2, 32'h4);
        check("t5.lat2.ins_vld_end", {31'b0, ins_vld_2}, 32'h0);
      end
    end

    // reset while a read is in flight
    op(16'h0020, 1'b1, 16'h0020, 4'h0, 32'h0, 4'hF);
    idle();
    #2;
    rstn = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("t6.lat2.ins_rst", ins_2, 32'h0);
    check("t6.lat1.dat_rd_rst", dat_rd_1, 32'h0);
    idle();
    rstn = 1'b0;
    for (int j = 0; j < 3; j++) begin
      idle();
      check("t6.lat2.no_ins_vld", {31'b0, ins_vld_2}, 32'h0);
      check("t6.lat2.no_dat_vld", {31'b0, dat_vld_2}, 32'h0);
    end
    op(16'h0, 1'b0, 16'h0020, 4'h0, 32'h0, 4'hF);
    idle();
    check("t6.lat1.retained", dat_rd_1, 32'h12345678);
    idle();
    check("t6.lat2.retained", dat_rd_2, 32'h12345678);

    // randomized traffic, including shared addresses and out-of-range hits
    for (int n = 0; n < 500; n++) begin
      logic [15:0] da, ia;
      logic [3:0]  we, re;
      da = 16'($urandom_range(0, 'h4FF));
      if ($urandom_range(0, 15) == 0) da = 16'($urandom_range(0, 'hFFFF));
      ia = ($urandom_range(0, 1) == 1) ? da : 16'($urandom_range(0, 'h4FF));
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      re = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      op(ia, 1'($urandom_range(0, 1)), da, we, $urandom, re);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcm_dual_port.md
Name: tcm_dual_port

Overview:
Parametrised dual-port tightly-coupled memory for the RISC-V core. It provides an instruction read port and a data read/write port with byte lanes, both into one shared word array. It replaces the separate fixed-size instruction and data SRAMs. It adds configurable width, depth and read latency, write-first forwarding, valid strobes and out-of-range detection.

Parameters:
DW, 32, data word width in bits; multiple of 8; NB = DW/8 byte lanes, LB = log2(NB).
AW, 14, word-address width; depth = 2**AW words.
ADR_W, 16, byte-address width of both ports; must be >= AW+LB.
RD_LAT, 1, read latency in cycles; legal values are 1 or 2.

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-high
ins_a  input  ADR_W  instruction byte address
ins_e  input  1  instruction read request
ins  output  DW  instruction read data
ins_vld  output  1  ins valid strobe
dat_a  input  ADR_W  data byte address
dat_we  input  NB  per-lane write enable
dat_wd  input  DW  write data
dat_re  input  NB  per-lane read enable
dat_rd  output  DW  read data
dat_vld  output  1  dat_rd valid strobe (any dat_re lane was set)
dat_err  output  1  out-of-range strobe for a data access

Behaviour:
- Reset is on clk, rstn, asynchronous, active-high. While rstn=1, all of these are 0: ins, ins_vld, dat_rd, dat_vld, dat_err, and every read-pipeline register.
- In-flight reads are discarded on reset. The memory array is not reset; contents are retained.
- Word index = a[AW+LB-1:LB]. Bits a[LB-1:0] are ignored, so accesses are always word-aligned.
- Out of range: any of a[ADR_W-1:AW+LB] is nonzero. Only possible when ADR_W > AW+LB.
- Requests are sampled at rising edge N.
- Writes: at edge N, each lane i with dat_we[i]=1 stores dat_wd[8i+:8]. Out-of-range writes are suppressed.
- RD_LAT=1: ins, ins_vld, dat_rd, dat_vld and dat_err update at edge N+1 (registered address, combinational array read).
- RD_LAT=2: the same outputs update at edge N+2, via one extra output register stage. Back-to-back requests are fully pipelined, one per cycle per port.
- ins_vld = ins_e delayed RD_LAT cycles.
- When ins_e=0, ins holds its previous value.
- dat_rd lane i is updated only if dat_re[i]=1; lanes not enabled hold their previous value.
- dat_vld = (|dat_re) delayed RD_LAT cycles.
- Out-of-range data read: enabled lanes return 0, and dat_err=1 in the same cycle as dat_vld. A write-only out-of-range access also asserts dat_err, RD_LAT cycles after the request.
- Out-of-range instruction read returns 0. It has no error flag; ins_vld still asserts.
- Write-first: a read on either port at edge N to the same word written at edge N returns the new bytes for the written lanes and the old bytes for the other lanes.
- Simultaneous dat_we and dat_re on the same word is legal and follows the write-first rule.
- Simultaneous ins and dat reads of the same word are both served; there is no arbitration and no stall.
- Reset asserted mid-pipeline (RD_LAT=2): no vld strobe is emitted for requests accepted before reset. Writes completed at edges before reset persist.
- Contents after power-up are undefined (X) until written, or preloaded by the bench through hierarchical access to the array.

Test Plan:
- Reset, then write dat_a=0x0010, dat_we=4'hF, dat_wd=0xDEADBEEF. Next cycle read dat_re=4'hF at the same address -> at edge+RD_LAT: dat_rd=0xDEADBEEF, dat_vld=1, dat_err=0.
- Byte lanes: word 4 = 0x11223344; write dat_we=4'b0101, dat_wd=0xAABBCCDD -> word reads 0x11BB33DD. Then read dat_re=4'b0011 with prior dat_rd=0xFFFFFFFF -> dat_rd=0xFFFF33DD.
- Write-first: same cycle dat_we=4'hF, dat_wd=0x12345678 to word 8, plus ins_e=1 with ins_a=0x0020 -> ins=0x12345678, ins_vld=1 after RD_LAT.
- Out of range (AW=8, ADR_W=16): write 0xCAFEF00D to dat_a=0x0400 -> dat_err=1 and word 0 unchanged. A read at 0x0400 with dat_re=4'hF -> dat_rd=0, dat_err=1.
- RD_LAT=2 pipelining: ins_e=1 on 4 consecutive cycles at addresses 0,4,8,C (preloaded 1,2,3,4) -> ins=1,2,3,4 on consecutive cycles starting 2 edges after the first request, with ins_vld high for 4 cycles.
- Reset mid-operation: with RD_LAT=2, issue a read, then assert rstn=1 one cycle later -> ins_vld and dat_vld never pulse for that read, all outputs are 0, and the previously written data reads back intact after reset.
